ha_mux4: RTL and testbench
==========================

// Module: ha_mux4
// PURPOSE
//   Registered 4:1 single-bit multiplexer. Selects one bit of a 4-bit input
//   vector by a 2-bit select code and presents it on a registered output.
//   Leaf datapath cell used wherever a clocked bit-select from a small bus is
//   needed; no handshake with neighbours beyond a load enable.
// PARAMETERS
//   N_IN     4   number of input bits; must equal 2**SEL_W
//   SEL_W    2   select width
//   RST_VAL  1'b0  value loaded into out on reset
// PORTS
//   clk     in   1      rising-edge clock; only clock in the block
//   rst     in   1      synchronous, active-high reset
//   en      in   1      load enable; 1 = capture selected bit this edge
//   in      in   N_IN   data bits; in[k] chosen when select==k
//   select  in   SEL_W  binary select code, select[0] is LSB
//   out     out  1      registered selected bit
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-high.
//   - Reset: on a rising clk edge with rst=1, out <= RST_VAL (0). rst has
//     priority over en; asserting rst mid-stream discards any pending load.
//   - Load: on a rising edge with rst=0 and en=1, out <= in[select].
//   - Hold: rst=0, en=0 -> out keeps its previous value indefinitely.
//   - Latency: 1 clock from in/select sampled to out valid (2 with
//     HA_IN_REG_EN, see CONFIGURATION).
//   - Select decode: 00->in[0], 01->in[1], 10->in[2], 11->in[3]. Full decode;
//     every code is legal, no out-of-range case for N_IN=4.
//   - in and select are sampled together on the same edge; a simultaneous
//     change of both is taken as one new (data, select) pair.
//   - Before the first reset, out is undefined; benches must reset first.
//   - No combinational path from any input to out.
//   - Elaboration check: N_IN != 2**SEL_W is a fatal error.
// CONFIGURATION
//   HA_IN_REG_EN
//   - Defined: adds an input pipeline register for in and select (captured
//     when en=1, reset to 0 by rst). out <= in_q[select_q] on the following
//     enabled edge. Latency 2 enabled clocks; en gates both stages.
//   - Undefined: single register stage, latency 1 as above.
//   - Reset value and decode table identical in both builds.
// TESTING
//   1. rst=1 for 2 clks with in=4'b1111, select=2'b11 -> out=0 after
//      first edge; stays 0 while rst=1.
//   2. rst=0, en=1, in=4'b0000, select swept 00,01,10,11 -> out=0 every
//      cycle.
//   3. en=1, in=4'b1010, select 00,01,10,11 -> out 0,1,0,1 one clk later
//      (two clks later with HA_IN_REG_EN).
//   4. en=1, in=4'b0100, select=10 -> out=1; then en=0, in=4'b0000,
//      select=00 for 3 clks -> out holds 1.
//   5. en=1, in=4'b1000, select=11 -> out=1; same edge rst=1 -> out=0
//      (reset wins), next clk rst=0 -> out=1.
//   6. Random in/select/en for 1000 clks vs. reference model with 1-clk
//      (or 2-clk) delay -> zero mismatches.

Source files
------------

// File: rtl/ha_mux4.sv
// Registered 4:1 single-bit mux: out <= in[select] on enabled edges, synchronous active-high reset.
// Build option: define HA_IN_REG_EN to add an input pipeline register for in/select (latency 2).
module ha_mux4 #(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned SEL_W   = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_IN-1:0]  in,
  input  logic [SEL_W-1:0] select,
  output logic             out
);

  localparam int unsigned DECODE_N = 1 << SEL_W;

  // The select code must address every input bit exactly once.
  if (N_IN != DECODE_N) begin : g_bad_cfg
    $fatal(1, "ha_mux4: N_IN must equal 2**SEL_W");
  end

  logic [N_IN-1:0]  data_c;
  logic [SEL_W-1:0] code_c;
  logic             sel_bit_c;

`ifdef HA_IN_REG_EN
  logic [N_IN-1:0]  in_q;
  logic [SEL_W-1:0] select_q;

  // Input stage: (data, select) captured as one pair on enabled edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q     <= '0;
      select_q <= '0;
    end else if (en) begin
      in_q     <= in;
      select_q <= select;
    end
  end

  always_comb begin
    data_c = in_q;
    code_c = select_q;
  end
`else
  always_comb begin
    data_c = in;
    code_c = select;
  end
`endif

  always_comb begin
    sel_bit_c = data_c[code_c];
  end

  // Output stage: reset has priority over load; hold when en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= RST_VAL;
    end else if (en) begin
      out <= sel_bit_c;
    end
  end

endmodule

// File: tb/tb_ha_mux4.sv
// Scoreboard bench for ha_mux4: driver pushes model predictions, monitor pops and compares each cycle.
// Compile with HA_IN_REG_EN defined to check the two-stage build.
module tb_ha_mux4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [3:0] in  = 4'b0000;
  logic [1:0] select = 2'b00;
  logic       out;

  typedef struct {
    logic exp;
    int   tag;
  } sb_item_t;

  sb_item_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: last output value and the pending captured pair.
  logic       m_out = 1'b0;
  logic [3:0] m_in  = 4'b0000;
  logic [1:0] m_sel = 2'b00;

  ha_mux4 dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .in(in),
    .select(select),
    .out(out)
  );

  always #5 clk = ~clk;

  // Drive one cycle at the falling edge and record what out must be after the next rising edge.
  task automatic drive(input logic r, input logic e, input logic [3:0] d, input logic [1:0] s,
                       input int tag);
    sb_item_t it;
    @(negedge clk);
    rst = r;
    en = e;
    in = d;
    select = s;
    if (r) begin
      m_out = 1'b0;
      m_in  = 4'b0000;
      m_sel = 2'b00;
    end else if (e) begin
`ifdef HA_IN_REG_EN
      m_out = 1'((m_in >> m_sel) & 4'd1);
      m_in  = d;
      m_sel = s;
`else
      m_out = 1'((d >> s) & 4'd1);
`endif
    end
    it.exp = m_out;
    it.tag = tag;
    sb_q.push_back(it);
  endtask

  // Monitor: out is a registered value presented every cycle; compare 1 time unit after the edge.
  always @(posedge clk) begin
    sb_item_t it;
    #1;
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      checks++;
      if (out !== it.exp) begin
        errors++;
        $display("FAIL test%0d: out=%b expected=%b at t=%0t", it.tag, out, it.exp, $time);
      end
    end
  end

  initial begin
    int k;
    // Test 1: reset held two clocks with all-ones data.
    drive(1'b1, 1'b1, 4'b1111, 2'b11, 1);
    drive(1'b1, 1'b1, 4'b1111, 2'b11, 1);
    // Test 2: zeros on every select code.
    for (int s = 0; s < 4; s++) drive(1'b0, 1'b1, 4'b0000, 2'(s), 2);
    // Test 3: alternating pattern.
    for (int s = 0; s < 4; s++) drive(1'b0, 1'b1, 4'b1010, 2'(s), 3);
    drive(1'b0, 1'b1, 4'b1010, 2'b11, 3);
    // Test 4: load a one then hold with en low.
    drive(1'b0, 1'b1, 4'b0100, 2'b10, 4);
    drive(1'b0, 1'b1, 4'b0100, 2'b10, 4);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'b0000, 2'b00, 4);
    // Test 5: reset wins over a simultaneous load, then reload.
    drive(1'b0, 1'b1, 4'b1000, 2'b11, 5);
    drive(1'b0, 1'b1, 4'b1000, 2'b11, 5);
    drive(1'b1, 1'b1, 4'b1000, 2'b11, 5);
    drive(1'b0, 1'b1, 4'b1000, 2'b11, 5);
    drive(1'b0, 1'b1, 4'b1000, 2'b11, 5);
    // Test 6: random traffic.
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
            4'($urandom), 2'($urandom), 6);
    end
    // Drain the scoreboard with a bounded wait.
    k = 0;
    while (sb_q.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #2;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
